// File: rtl/switch_arbiter_if.sv
// Handshake bundle between the requesters and the switch arbiter.
// The master side is the control logic; the slave side is the arbiter itself.
interface switch_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_state;
  logic [NUM_REQ-1:0] grant;
  logic               switch;
  logic               busy;
  logic [15:0]        toggle_count;

  modport master (
    output req, req_state,
    input  grant, switch, busy, toggle_count
  );

  modport slave (
    input  req, req_state,
    output grant, switch, busy, toggle_count
  );
endinterface

// File: rtl/switch_arbiter.sv
// Round-robin arbiter that owns a single registered switch and enforces a
// minimum dwell time after every real change of the switch value.
module switch_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  switch_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_n;
  logic [PTR_W-1:0]   ptr_q, ptr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               switch_q, switch_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [15:0]        toggle_q, toggle_n;

  logic               found;
  logic [PTR_W-1:0]   win;
  int                 idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      switch_q <= 1'b0;
      grant_q  <= '0;
      toggle_q <= '0;
    end else begin
      state_q  <= state_n;
      ptr_q    <= ptr_n;
      cnt_q    <= cnt_n;
      switch_q <= switch_n;
      grant_q  <= grant_n;
      toggle_q <= toggle_n;
    end
  end

  // Winner is the first set request strictly after the last grant, wrapping;
  // offset NUM_REQ brings the search back to the last winner itself.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    cnt_n    = cnt_q;
    switch_n = switch_q;
    toggle_n = toggle_q;
    grant_n  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_n[win] = 1'b1;
          ptr_n        = win;
          // Only a real change of the switch value starts a dwell period.
          if (bus.req_state[win] != switch_q) begin
            switch_n = bus.req_state[win];
            toggle_n = toggle_q + 16'd1;
            cnt_n    = CNT_W'(HOLD_CYCLES - 1);
            state_n  = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.grant        = grant_q;
  assign bus.switch       = switch_q;
  assign bus.busy         = (state_q == HOLD);
  assign bus.toggle_count = toggle_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter with NUM_REQ=4, HOLD_CYCLES=8.
// Expected values are hand-derived from the arbiter's documented behaviour.
module tb_switch_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  switch_arbiter_if #(.NUM_REQ(4)) bus ();

  switch_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(8), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until a grant appears; cycles is the number of edges taken.
  task automatic wait_grant(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      cycles = i;
      if (bus.grant != 4'b0000) break;
    end
    check("grant_timeout", {31'd0, bus.grant != 4'b0000}, 32'd1);
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b1;
    #1;
    check("rst_switch", {31'd0, bus.switch}, 32'd0);
    check("rst_busy",   {31'd0, bus.busy},   32'd0);
    check("rst_grant",  {28'd0, bus.grant},  32'd0);
    check("rst_toggle", {16'd0, bus.toggle_count}, 32'd0);
    #2 reset = 1'b0;
  endtask

  logic [3:0] rr_expect [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int cyc;
    bus.req       = '0;
    bus.req_state = '0;

    // Reset asserted between edges, observed without any clock edge.
    pulse_reset();

    // Single change from requester 0.
    bus.req = 4'b0001; bus.req_state = 4'b0001;
    step();
    check("single_grant",  {28'd0, bus.grant}, 32'h1);
    check("single_switch", {31'd0, bus.switch}, 32'd1);
    check("single_toggle", {16'd0, bus.toggle_count}, 32'd1);
    check("single_busy0",  {31'd0, bus.busy}, 32'd1);
    bus.req = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("single_busy", {31'd0, bus.busy}, 32'd1);
      check("single_grant_off", {28'd0, bus.grant}, 32'd0);
    end
    step();
    check("single_busy_end", {31'd0, bus.busy}, 32'd0);

    // Round robin with every grant a real change.
    pulse_reset();
    bus.req = 4'b1111; bus.req_state = 4'b0101;
    for (int g = 0; g < 5; g++) begin
      wait_grant(cyc);
      check("rr_grant",  {28'd0, bus.grant}, {28'd0, rr_expect[g]});
      check("rr_switch", {31'd0, bus.switch}, (g % 2 == 0) ? 32'd1 : 32'd0);
      if (g == 0) check("rr_first_gap", cyc, 32'd1);
      else        check("rr_gap", cyc, 32'd9);
    end
    check("rr_toggle", {16'd0, bus.toggle_count}, 32'd5);
    bus.req = 4'b0000;
    for (int k = 0; k < 8; k++) step();
    check("rr_idle", {31'd0, bus.busy}, 32'd0);

    // No-op grants back to back.
    pulse_reset();
    bus.req = 4'b0110; bus.req_state = 4'b0000;
    step();
    check("noop_grant1", {28'd0, bus.grant}, 32'h2);
    check("noop_busy1",  {31'd0, bus.busy}, 32'd0);
    bus.req = 4'b0100;
    step();
    check("noop_grant2", {28'd0, bus.grant}, 32'h4);
    check("noop_busy2",  {31'd0, bus.busy}, 32'd0);
    check("noop_switch", {31'd0, bus.switch}, 32'd0);
    check("noop_toggle", {16'd0, bus.toggle_count}, 32'd0);
    bus.req = 4'b0000;
    step();
    check("noop_idle_grant", {28'd0, bus.grant}, 32'd0);

    // Requests raised during HOLD wait for IDLE.
    bus.req = 4'b0001; bus.req_state = 4'b0001;
    step();
    check("hb_grant0", {28'd0, bus.grant}, 32'h1);
    bus.req = 4'b1000; bus.req_state = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("hb_blocked", {28'd0, bus.grant}, 32'd0);
      check("hb_busy",    {31'd0, bus.busy}, 32'd1);
    end
    step();
    check("hb_busy_fall", {31'd0, bus.busy}, 32'd0);
    check("hb_still_blocked", {28'd0, bus.grant}, 32'd0);
    step();
    check("hb_grant3",  {28'd0, bus.grant}, 32'h8);
    check("hb_switch",  {31'd0, bus.switch}, 32'd0);
    check("hb_toggle",  {16'd0, bus.toggle_count}, 32'd2);
    bus.req = 4'b0000;
    for (int k = 0; k < 8; k++) step();

    // Reset in the middle of a dwell with the switch driven high.
    bus.req = 4'b0001; bus.req_state = 4'b0001;
    step();
    check("mh_switch_hi", {31'd0, bus.switch}, 32'd1);
    bus.req = 4'b0000;
    step(); step();
    check("mh_busy_hi", {31'd0, bus.busy}, 32'd1);
    #3 reset = 1'b1;
    bus.req = 4'b0010; bus.req_state = 4'b0010;
    #1;
    check("mh_switch", {31'd0, bus.switch}, 32'd0);
    check("mh_busy",   {31'd0, bus.busy}, 32'd0);
    check("mh_toggle", {16'd0, bus.toggle_count}, 32'd0);
    step();
    check("mh_held", {28'd0, bus.grant}, 32'd0);
    #2 reset = 1'b0;
    step();
    check("mh_grant",  {28'd0, bus.grant}, 32'h2);
    check("mh_switch_after", {31'd0, bus.switch}, 32'd1);
    bus.req = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Round-robin arbiter that shares a single registered switch output among several requesters. Each requester asks for a switch state (ON or OFF). The arbiter grants one requester at a time and drives the switch to that state. After every real state change it enforces a minimum dwell time so the switch cannot chatter. The block sits between the control logic that wants the switch changed and the switch pin itself, and is the only driver of that pin.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `HOLD_CYCLES`, default 8: minimum clock cycles the switch holds after a change; legal range 1..65535.
- `CNT_W`, default 16: width of the internal dwell counter; must satisfy 2^CNT_W > HOLD_CYCLES.
- `clock`, input, 1: single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset. Clears all state immediately. Release is synchronous to `clock`.
- `req`, input, NUM_REQ: level request, one bit per requester.
- `req_state`, input, NUM_REQ: desired switch value per requester. Valid only where the matching `req` bit is 1.
- `grant`, output, NUM_REQ: one-hot, single-cycle grant pulse. All zero when idle.
- `switch`, output, 1: registered switch state.
- `busy`, output, 1: high while the dwell period is running.
- `toggle_count`, output, 16: count of real switch changes since reset; wraps modulo 2^16.

## Operation
- Reset values: `switch`=0, `grant`=0, `busy`=0, `toggle_count`=0, state=IDLE, last-grant pointer=NUM_REQ-1. With these values requester 0 has first priority.
- There are two states: IDLE and HOLD. `busy` equals (state==HOLD), driven from a register.
- Winner selection in IDLE with `req`≠0:
  - The winner `w` is the first set `req` bit searching from index last+1 upward, wrapping modulo NUM_REQ.
  - On that edge: `grant[w]` is set to 1 and the pointer is set to `w`.
- Real change, when `req_state[w]` ≠ `switch`:
  - `switch` is set to `req_state[w]` and `toggle_count` is incremented by 1.
  - The dwell counter is loaded with HOLD_CYCLES-1 and state moves to HOLD.
- No-op, when `req_state[w]` == `switch`:
  - `grant[w]` still pulses and the pointer still advances.
  - `switch` and `toggle_count` are unchanged and state stays IDLE. No dwell is applied.
- In HOLD:
  - `grant` is 0 and `req` is ignored.
  - If the counter is 0, state returns to IDLE; otherwise the counter decrements.
- In IDLE with `req`=0: no grant is issued and nothing changes.
- Requester contract:
  - Requests are level-sensitive. A requester should drop `req` the cycle after it sees its grant.
  - A requester that holds `req` high is granted again only after every other active requester has had its turn (round-robin fairness).
- Changes to `req`/`req_state` while in HOLD have no effect until the arbiter is back in IDLE.
- Reset asserted mid-HOLD or on a grant cycle: all outputs return to their reset values at once. Any in-flight request is discarded, and the switch goes to 0 even if it was 1.

## Timing
- Grant latency: `req` sampled high at edge N (state IDLE) gives `grant`, and the new `switch` value, visible after edge N. Both update on the same edge.
- `grant` is exactly one cycle wide.
- After a real change at edge N:
  - `busy`=1 after edges N through N+HOLD_CYCLES-1, i.e. for exactly HOLD_CYCLES cycles.
  - IDLE again after edge N+HOLD_CYCLES.
  - The earliest next grant is at edge N+HOLD_CYCLES+1.
  - The switch therefore keeps its value for at least HOLD_CYCLES+1 cycles.
- No-op grants back-to-back: one grant per cycle is possible.
- Sustained requests that toggle every time: one grant every HOLD_CYCLES+1 cycles.
- `toggle_count` wraps 0xFFFF → 0x0000 with no flag.
- There is no combinational path from any input to any output.

## Test plan
- Reset: assert `reset` between clock edges. Expect `switch`=0, `grant`=0, `busy`=0, `toggle_count`=0 immediately, without waiting for a clock edge.
- Single change: `req`=0001, `req_state`=0001, HOLD_CYCLES=8. Expect:
  - `grant`=0001 for 1 cycle, with `switch`=1 on that same cycle.
  - `busy` high for 8 cycles.
  - `toggle_count`=1.
- Round-robin: `req`=1111 held, with `req_state` alternating so every grant is a change. Expect:
  - Grant order 0001, 0010, 0100, 1000, 0001.
  - Successive grants 9 cycles apart.
  - `switch` alternating.
- No-op grant: with `switch`=0, `req`=0110 and `req_state`=0000. Expect:
  - `grant`=0010, then 0100 on the next cycle.
  - `busy` stays 0, `toggle_count` and `switch` unchanged.
- Hold blocking: start a change, then raise `req[3]` during HOLD. Expect:
  - No grant while `busy`=1.
  - `grant`=1000 on the first cycle after `busy` falls.
- Reset mid-HOLD: assert `reset` at HOLD cycle 3 with `switch`=1. Expect:
  - `switch`=0, `busy`=0, `toggle_count`=0.
  - After release with `req`=0010 pending, the first grant is 0010 one cycle later.
